// File: rtl/cb_cfg_pkg.sv
// Shared types and sizing helpers for the connection-block configuration loader.
// The c-bus width comes from cb_nbits so the loader and the connection block always agree.
package cb_cfg_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        COMMIT = 2'd2,
        RDBK   = 2'd3
    } cfg_state_e;

    function automatic int cb_nbits(
        input int ws,
        input int wd,
        input int wg,
        input int clbin0,
        input int clbin1,
        input int clbout0,
        input int clbout1,
        input int clbos,
        input int clbod,
        input int clbx
    );
        return clbout0 * (clbos + clbod) + clbin0 * (ws + wd + wg + clbx * clbout1)
             + clbout1 * (clbos + clbod) + clbin1 * (ws + wd + wg + clbx * clbout0);
    endfunction

    function automatic int nwords(input int nbits, input int w);
        return (nbits + w - 1) / w;
    endfunction

endpackage

// File: rtl/cb_cfg_shifter.sv
// Shadow shift register: each accepted word enters at the top so the first word ends up lowest.
// Only the low OUTW bits are exposed; the pad bits of the last word never leave this module.
module cb_cfg_shifter #(
    parameter int PW   = 256,
    parameter int W    = 16,
    parameter int OUTW = 248
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            shift_en,
    input  logic [W-1:0]    din,
    output logic [OUTW-1:0] q
);

    logic [PW-1:0] shadow_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow_q <= '0;
        end else if (shift_en) begin
            shadow_q <= {din, shadow_q[PW-1:W]};
        end
    end

    assign q = shadow_q[OUTW-1:0];

endmodule

// File: rtl/cb_config_loader.sv
// Loads one connection block's switch pattern word by word, then commits it atomically to cfg_out.
// Optional readback of the active pattern is enabled by defining CB_CFG_READBACK_EN.
module cb_config_loader
    import cb_cfg_pkg::*;
#(
    parameter int WS      = 8,
    parameter int WD      = 8,
    parameter int WG      = 3,
    parameter int CLBIN0  = 6,
    parameter int CLBIN1  = 6,
    parameter int CLBOUT0 = 1,
    parameter int CLBOUT1 = 1,
    parameter int CLBOS   = 2,
    parameter int CLBOD   = 2,
    parameter int CLBX    = 1,
    parameter int CFG_W   = 16,
    localparam int NBITS  = cb_nbits(WS, WD, WG, CLBIN0, CLBIN1, CLBOUT0, CLBOUT1, CLBOS, CLBOD, CLBX),
    localparam int NWORDS = nwords(NBITS, CFG_W),
    localparam int PW     = NWORDS * CFG_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [CFG_W-1:0] cfg_data,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    output logic             busy,
    output logic             done,
    output logic [NBITS-1:0] cfg_out
`ifdef CB_CFG_READBACK_EN
    ,
    input  logic             rb_start,
    output logic [CFG_W-1:0] rb_data,
    output logic             rb_valid
`endif
);

    localparam int CW = $clog2(NWORDS + 1);
    localparam logic [CW-1:0] LAST = CW'(NWORDS - 1);

    cfg_state_e       state_q;
    logic [CW-1:0]    word_cnt_q;
    logic [NBITS-1:0] cfg_out_q;
    logic             done_q;
    logic [NBITS-1:0] shadow;
    logic             accept;

    // Abort wins over a word offered in the same cycle.
    assign accept    = (state_q == LOAD) && cfg_valid && !abort;
    assign cfg_ready = (state_q == LOAD);
    assign busy      = (state_q != IDLE);
    assign done      = done_q;
    assign cfg_out   = cfg_out_q;

    cb_cfg_shifter #(
        .PW   (PW),
        .W    (CFG_W),
        .OUTW (NBITS)
    ) u_shifter (
        .clk      (clk),
        .rst      (rst),
        .shift_en (accept),
        .din      (cfg_data),
        .q        (shadow)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            word_cnt_q <= '0;
            cfg_out_q  <= '0;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q    <= LOAD;
                        word_cnt_q <= '0;
                    end
`ifdef CB_CFG_READBACK_EN
                    else if (rb_start) begin
                        state_q    <= RDBK;
                        word_cnt_q <= '0;
                    end
`endif
                end
                LOAD: begin
                    if (abort) begin
                        state_q <= IDLE;
                    end else if (cfg_valid) begin
                        word_cnt_q <= word_cnt_q + CW'(1);
                        if (word_cnt_q == LAST) begin
                            state_q <= COMMIT;
                        end
                    end
                end
                COMMIT: begin
                    cfg_out_q <= shadow;
                    done_q    <= 1'b1;
                    state_q   <= IDLE;
                end
                RDBK: begin
`ifdef CB_CFG_READBACK_EN
                    word_cnt_q <= word_cnt_q + CW'(1);
                    if (word_cnt_q == LAST) begin
                        state_q <= IDLE;
                    end
`else
                    state_q <= IDLE;
`endif
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef CB_CFG_READBACK_EN
    logic [PW-1:0] rb_pad;

    assign rb_pad   = PW'(cfg_out_q);
    assign rb_valid = (state_q == RDBK);

    // Word select for readback; zero outside RDBK so the bus is quiet when idle.
    always_comb begin
        rb_data = '0;
        if (state_q == RDBK) begin
            for (int k = 0; k < NWORDS; k++) begin
                if (word_cnt_q == CW'(k)) begin
                    rb_data = rb_pad[k*CFG_W +: CFG_W];
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_cb_config_loader.sv
// Directed bench for cb_config_loader at default parameters (NBITS=248, CFG_W=16, NWORDS=16).
// Readback steps are compiled in only when CB_CFG_READBACK_EN is defined.
module tb_cb_config_loader;

    localparam int NB = 248;

    logic          clk;
    logic          rst;
    logic          start;
    logic          abort;
    logic [15:0]   cfg_data;
    logic          cfg_valid;
    logic          cfg_ready;
    logic          busy;
    logic          done;
    logic [NB-1:0] cfg_out;
`ifdef CB_CFG_READBACK_EN
    logic          rb_start;
    logic [15:0]   rb_data;
    logic          rb_valid;
`endif

    int checks   = 0;
    int failures = 0;

    cb_config_loader dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .abort     (abort),
        .cfg_data  (cfg_data),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .busy      (busy),
        .done      (done),
        .cfg_out   (cfg_out)
`ifdef CB_CFG_READBACK_EN
        ,
        .rb_start  (rb_start),
        .rb_data   (rb_data),
        .rb_valid  (rb_valid)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [255:0] observed, input logic [255:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Expected pattern after a load of words base, base+1, ...; pad byte of the last word dropped.
    function automatic logic [NB-1:0] expVec(input logic [15:0] base, input bit inc);
        logic [255:0] f;
        f = '0;
        for (int k = 0; k < 16; k++) begin
            f[k*16 +: 16] = inc ? base + 16'(k) : base;
        end
        return f[NB-1:0];
    endfunction

    // Called at a negedge in IDLE: issues start, then offers n words; optional idle gap before each
    // word, and a stray start pulse in the gap before word startAt.
    task automatic applyStimulus(input logic [15:0] base, input bit inc, input int n,
                                 input bit gaps, input int startAt);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < n; k++) begin
            if (gaps) begin
                cfg_valid = 1'b0;
                cfg_data  = 16'hDEAD;
                if (k == startAt) start = 1'b1;
                @(negedge clk);
                start = 1'b0;
            end
            cfg_valid = 1'b1;
            cfg_data  = inc ? base + 16'(k) : base;
            checkOutput("ready_in_load", 256'(cfg_ready), 256'(1'b1));
            checkOutput("no_done_in_load", 256'(done), 256'(1'b0));
            @(negedge clk);
        end
        cfg_valid = 1'b0;
        cfg_data  = 16'h0000;
    endtask

    // Called at the negedge right after the last accepting edge (state COMMIT).
    task automatic finishLoad(input string tag, input logic [NB-1:0] expected);
        checkOutput({tag, "_commit_ready"}, 256'(cfg_ready), 256'(1'b0));
        checkOutput({tag, "_commit_busy"}, 256'(busy), 256'(1'b1));
        checkOutput({tag, "_commit_done"}, 256'(done), 256'(1'b0));
        @(negedge clk);
        checkOutput({tag, "_done"}, 256'(done), 256'(1'b1));
        checkOutput({tag, "_busy_after"}, 256'(busy), 256'(1'b0));
        checkOutput({tag, "_cfg_out"}, 256'(cfg_out), 256'(expected));
        checkOutput({tag, "_low_word"}, 256'(cfg_out[15:0]), 256'(expected[15:0]));
        checkOutput({tag, "_top_byte"}, 256'(cfg_out[247:240]), 256'(expected[247:240]));
        @(negedge clk);
        checkOutput({tag, "_done_pulse"}, 256'(done), 256'(1'b0));
    endtask

    initial begin
        logic [NB-1:0] vecCount;
        logic [NB-1:0] vecA5;

        vecCount = expVec(16'h0000, 1'b1);
        vecA5    = expVec(16'hA500, 1'b1);

        rst       = 1'b1;
        start     = 1'b0;
        abort     = 1'b0;
        cfg_data  = 16'h0000;
        cfg_valid = 1'b0;
`ifdef CB_CFG_READBACK_EN
        rb_start  = 1'b0;
`endif

        #1;
        checkOutput("reset_cfg_out", 256'(cfg_out), 256'(0));
        checkOutput("reset_ready", 256'(cfg_ready), 256'(1'b0));
        checkOutput("reset_busy", 256'(busy), 256'(1'b0));
        checkOutput("reset_done", 256'(done), 256'(1'b0));
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        $display("[TB] full load 0000..000F");
        applyStimulus(16'h0000, 1'b1, 16, 1'b0, -1);
        finishLoad("full", vecCount);
        checkOutput("full_word0", 256'(cfg_out[15:0]), 256'(16'h0000));
        checkOutput("full_pad_drop", 256'(cfg_out[247:240]), 256'(8'h0F));

`ifdef CB_CFG_READBACK_EN
        $display("[TB] readback");
        rb_start = 1'b1;
        @(negedge clk);
        rb_start = 1'b0;
        for (int k = 0; k < 16; k++) begin
            checkOutput("rb_valid", 256'(rb_valid), 256'(1'b1));
            checkOutput("rb_busy", 256'(busy), 256'(1'b1));
            checkOutput("rb_data", 256'(rb_data), 256'(16'(k)));
            @(negedge clk);
        end
        checkOutput("rb_valid_end", 256'(rb_valid), 256'(1'b0));
        checkOutput("rb_data_end", 256'(rb_data), 256'(16'h0000));
        checkOutput("rb_busy_end", 256'(busy), 256'(1'b0));
`endif

        $display("[TB] abort after 7 words");
        applyStimulus(16'hFFFF, 1'b0, 7, 1'b0, -1);
        abort     = 1'b1;
        cfg_valid = 1'b1;
        cfg_data  = 16'hFFFF;
        @(negedge clk);
        abort     = 1'b0;
        cfg_valid = 1'b0;
        checkOutput("abort_busy", 256'(busy), 256'(1'b0));
        checkOutput("abort_ready", 256'(cfg_ready), 256'(1'b0));
        checkOutput("abort_done", 256'(done), 256'(1'b0));
        checkOutput("abort_cfg_out", 256'(cfg_out), 256'(vecCount));
        repeat (3) @(negedge clk);
        checkOutput("abort_no_late_done", 256'(done), 256'(1'b0));
        checkOutput("abort_cfg_hold", 256'(cfg_out), 256'(vecCount));

        $display("[TB] reload after abort");
        applyStimulus(16'hA500, 1'b1, 16, 1'b0, -1);
        finishLoad("reload", vecA5);

        $display("[TB] valid without start");
        cfg_valid = 1'b1;
        cfg_data  = 16'h1234;
        repeat (3) begin
            @(negedge clk);
            checkOutput("idle_ready", 256'(cfg_ready), 256'(1'b0));
            checkOutput("idle_busy", 256'(busy), 256'(1'b0));
            checkOutput("idle_cfg_out", 256'(cfg_out), 256'(vecA5));
        end
        cfg_valid = 1'b0;

        $display("[TB] gapped load with stray start");
        applyStimulus(16'h0000, 1'b1, 16, 1'b1, 5);
        finishLoad("gaps", vecCount);

        $display("[TB] async reset mid-load");
        applyStimulus(16'h5555, 1'b0, 3, 1'b0, -1);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("rst_mid_cfg_out", 256'(cfg_out), 256'(0));
        checkOutput("rst_mid_ready", 256'(cfg_ready), 256'(1'b0));
        checkOutput("rst_mid_busy", 256'(busy), 256'(1'b0));
        checkOutput("rst_mid_done", 256'(done), 256'(1'b0));
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("post_rst_idle", 256'(busy), 256'(1'b0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
